// File: rtl/dram_cmd_signal_gen.sv
// DDR4 command/address pin driver: power-up pin sequence,
// command encoding, per-rank chip select, CA parity, 1T/2T timing.
module dram_cmd_signal_gen #(
  parameter int NUM_RANKS   = 2,
  parameter int BG_W        = 2,
  parameter int BA_W        = 2,
  parameter int ROW_W       = 17,
  parameter int COL_W       = 10,
  parameter int T_RESET_CYC = 200,
  parameter int T_CKE_CYC   = 500,
  parameter bit CMD_2T      = 1'b0,
  parameter bit PAR_EN      = 1'b1,
  localparam int RANK_W =
    (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_cmd,
  input  logic [RANK_W-1:0]    req_rank,
  input  logic [BG_W-1:0]      req_bg,
  input  logic [BA_W-1:0]      req_ba,
  input  logic [ROW_W-1:0]     req_row,
  input  logic [COL_W-1:0]     req_col,
  input  logic                 req_ap,
  output logic                 init_done,
  output logic                 RESET_n,
  output logic                 CKE,
  output logic [NUM_RANKS-1:0] CS_n,
  output logic                 ACT_n,
  output logic                 RAS_n_A16,
  output logic                 CAS_n_A15,
  output logic                 WE_n_A14,
  output logic [BG_W-1:0]      BG,
  output logic [BA_W-1:0]      BA,
  output logic [13:0]          ADDR,
  output logic                 ADDR_17,
  output logic                 PARITY
);

  localparam int CNT_MAX =
    (T_RESET_CYC > T_CKE_CYC) ? T_RESET_CYC : T_CKE_CYC;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [NUM_RANKS-1:0] RANK_ONE =
    NUM_RANKS'(1);

  typedef enum logic [1:0] {
    S_RST, S_CKE, S_IDLE, S_HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rstn_q, rstn_d;
  logic                 cke_q, cke_d;
  logic                 init_q, init_d;
  logic [NUM_RANKS-1:0] cs_q, cs_d;
  logic [NUM_RANKS-1:0] hcs_q, hcs_d;
  logic [3:0]           cmd_q, cmd_d;
  logic [BG_W-1:0]      bg_q, bg_d;
  logic [BA_W-1:0]      ba_q, ba_d;
  logic [13:0]          addr_q, addr_d;
  logic                 a17_q, a17_d;
  logic                 par_q, par_d;

  logic                 dec_ok;
  logic [3:0]           dec_cmd;
  logic [13:0]          dec_addr;
  logic                 dec_a17;
  logic [NUM_RANKS-1:0] dec_cs;
  logic [17:0]          row_x;
  logic [13:0]          rw_addr;

  // Decode the request into pin values; bad codes/ranks become DES.
  always_comb begin
    row_x      = 18'(req_row);
    rw_addr    = 14'(req_col);
    rw_addr[10] = req_ap;
    rw_addr[12] = 1'b1;
    dec_ok     = 1'b1;
    dec_cmd    = 4'hF;
    dec_addr   = '0;
    dec_a17    = 1'b0;
    unique case (1'b1)
      (req_cmd == 4'd1): dec_cmd = 4'hF;
      (req_cmd == 4'd2): begin
        dec_cmd  = {1'b0, row_x[16:14]};
        dec_addr = row_x[13:0];
        dec_a17  = row_x[17];
      end
      (req_cmd == 4'd3): begin
        dec_cmd  = 4'hD;
        dec_addr = rw_addr;
      end
      (req_cmd == 4'd4): begin
        dec_cmd  = 4'hC;
        dec_addr = rw_addr;
      end
      (req_cmd == 4'd5): dec_cmd = 4'hA;
      (req_cmd == 4'd6): begin
        dec_cmd      = 4'hA;
        dec_addr[10] = 1'b1;
      end
      (req_cmd == 4'd7): dec_cmd = 4'h9;
      (req_cmd == 4'd8): begin
        dec_cmd  = 4'h8;
        dec_addr = row_x[13:0];
      end
      (req_cmd == 4'd9): begin
        dec_cmd      = 4'hE;
        dec_addr[10] = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
    if (int'(req_rank) >= NUM_RANKS) dec_ok = 1'b0;
    dec_cs = ~(RANK_ONE << req_rank);
    if (!dec_ok) begin
      dec_cs  = '1;
      dec_cmd = 4'hF;
    end
  end

  // Sequencer next state and next pin values; DES by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rstn_d  = rstn_q;
    cke_d   = cke_q;
    init_d  = init_q;
    hcs_d   = hcs_q;
    cs_d    = '1;
    cmd_d   = 4'hF;
    bg_d    = bg_q;
    ba_d    = ba_q;
    addr_d  = addr_q;
    a17_d   = a17_q;
    unique case (state_q)
      S_RST: begin
        if (cnt_q == CNT_W'(T_RESET_CYC - 1)) begin
          state_d = S_CKE;
          cnt_d   = '0;
          rstn_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CKE: begin
        if (cnt_q == CNT_W'(T_CKE_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          cke_d   = 1'b1;
          init_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (req_valid) begin
          if (dec_ok) begin
            cmd_d  = dec_cmd;
            bg_d   = req_bg;
            ba_d   = req_ba;
            addr_d = dec_addr;
            a17_d  = dec_a17;
          end
          if (CMD_2T) begin
            state_d = S_HOLD;
            hcs_d   = dec_cs;
          end else begin
            cs_d = dec_cs;
          end
        end
      end
      S_HOLD: begin
        cmd_d   = cmd_q;
        cs_d    = hcs_q;
        state_d = S_IDLE;
      end
      default: state_d = S_RST;
    endcase
    par_d = PAR_EN &
      (^{cmd_d, bg_d, ba_d, addr_d, a17_d});
  end

  // State and pin registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      rstn_q  <= 1'b0;
      cke_q   <= 1'b0;
      init_q  <= 1'b0;
      hcs_q   <= '1;
      cs_q    <= '1;
      cmd_q   <= 4'hF;
      bg_q    <= '0;
      ba_q    <= '0;
      addr_q  <= '0;
      a17_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rstn_q  <= rstn_d;
      cke_q   <= cke_d;
      init_q  <= init_d;
      hcs_q   <= hcs_d;
      cs_q    <= cs_d;
      cmd_q   <= cmd_d;
      bg_q    <= bg_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      a17_q   <= a17_d;
      par_q   <= par_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign init_done = init_q;
  assign RESET_n   = rstn_q;
  assign CKE       = cke_q;
  assign CS_n      = cs_q;
  assign ACT_n     = cmd_q[3];
  assign RAS_n_A16 = cmd_q[2];
  assign CAS_n_A15 = cmd_q[1];
  assign WE_n_A14  = cmd_q[0];
  assign BG        = bg_q;
  assign BA        = ba_q;
  assign ADDR      = addr_q;
  assign ADDR_17   = a17_q;
  assign PARITY    = par_q;

endmodule

// File: tb/tb_dram_cmd_signal_gen.sv
// Bench for dram_cmd_signal_gen: a 1T/2-rank and a 2T/3-rank
// instance checked every cycle against a cycle-count pin model.
module tb_dram_cmd_signal_gen;

  localparam int TR = 4;
  localparam int TC = 6;

  typedef struct packed {
    logic        rn;
    logic        cke;
    logic        init;
    logic        rdy;
    logic [2:0]  cs;
    logic [3:0]  cmd;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [13:0] addr;
    logic        a17;
    logic        par;
  } pins_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [1:0]  rst;
  logic [1:0]  v;
  logic [3:0]  cmd;
  logic [1:0]  rank;
  logic [1:0]  bg;
  logic [1:0]  ba;
  logic [16:0] row;
  logic [9:0]  col;
  logic        ap;

  logic        rdy0, init0, rn0, cke0;
  logic        act0, ras0, cas0, we0, a170, par0;
  logic [1:0]  cs0, bg0, ba0;
  logic [13:0] addr0;
  logic        rdy1, init1, rn1, cke1;
  logic        act1, ras1, cas1, we1, a171, par1;
  logic [2:0]  cs1;
  logic [1:0]  bg1, ba1;
  logic [13:0] addr1;

  dram_cmd_signal_gen #(
    .NUM_RANKS(2), .T_RESET_CYC(TR), .T_CKE_CYC(TC),
    .CMD_2T(1'b0), .PAR_EN(1'b1)
  ) u_1t (
    .CLK(CLK), .RST(rst[0]), .req_valid(v[0]),
    .req_ready(rdy0), .req_cmd(cmd), .req_rank(rank[0]),
    .req_bg(bg), .req_ba(ba), .req_row(row), .req_col(col),
    .req_ap(ap), .init_done(init0), .RESET_n(rn0),
    .CKE(cke0), .CS_n(cs0), .ACT_n(act0),
    .RAS_n_A16(ras0), .CAS_n_A15(cas0), .WE_n_A14(we0),
    .BG(bg0), .BA(ba0), .ADDR(addr0), .ADDR_17(a170),
    .PARITY(par0)
  );

  dram_cmd_signal_gen #(
    .NUM_RANKS(3), .T_RESET_CYC(TR), .T_CKE_CYC(TC),
    .CMD_2T(1'b1), .PAR_EN(1'b1)
  ) u_2t (
    .CLK(CLK), .RST(rst[1]), .req_valid(v[1]),
    .req_ready(rdy1), .req_cmd(cmd), .req_rank(rank),
    .req_bg(bg), .req_ba(ba), .req_row(row), .req_col(col),
    .req_ap(ap), .init_done(init1), .RESET_n(rn1),
    .CKE(cke1), .CS_n(cs1), .ACT_n(act1),
    .RAS_n_A16(ras1), .CAS_n_A15(cas1), .WE_n_A14(we1),
    .BG(bg1), .BA(ba1), .ADDR(addr1), .ADDR_17(a171),
    .PARITY(par1)
  );

  pins_t dp [2];
  always_comb begin
    dp[0] = {rn0, cke0, init0, rdy0, {1'b0, cs0},
             {act0, ras0, cas0, we0}, bg0, ba0, addr0,
             a170, par0};
    dp[1] = {rn1, cke1, init1, rdy1, cs1,
             {act1, ras1, cas1, we1}, bg1, ba1, addr1,
             a171, par1};
  end

  int    nvec = 0;
  int    nerr = 0;
  bit    chk_en = 1'b0;
  pins_t ep [2];
  int    t [2];
  bit    pend [2];
  logic [2:0] hcs [2];

  // Model: pin state follows from cycles since reset release and
  // the command accepted on the previous edge (d=1 is 2T).
  task automatic step(int d);
    pins_t e;
    logic [2:0] all1, csv;
    logic [1:0] rk;
    logic [17:0] r;
    bit rdy_now, acc, ok;
    all1 = (d == 0) ? 3'b011 : 3'b111;
    if (rst[d]) begin
      t[d] = 0;
      pend[d] = 1'b0;
      hcs[d] = all1;
      e = '0;
      e.cs = all1;
      e.cmd = 4'hF;
      ep[d] = e;
      return;
    end
    e = ep[d];
    rdy_now = (t[d] >= TR + TC) && !pend[d];
    acc = rdy_now && v[d];
    if (t[d] < TR + TC) t[d]++;
    e.rn = (t[d] >= TR);
    e.cke = (t[d] >= TR + TC);
    e.init = e.cke;
    e.cs = all1;
    e.cmd = 4'hF;
    rk = (d == 0) ? {1'b0, rank[0]} : rank;
    if (pend[d]) begin
      e.cs = hcs[d];
      e.cmd = ep[d].cmd;
      pend[d] = 1'b0;
    end else if (acc) begin
      ok = (cmd >= 4'd1) && (cmd <= 4'd9) &&
           (int'(rk) < ((d == 0) ? 2 : 3));
      csv = all1;
      if (ok) begin
        r = {1'b0, row};
        csv = all1 & ~(3'b001 << rk);
        e.bg = bg;
        e.ba = ba;
        e.a17 = 1'b0;
        e.addr = '0;
        case (cmd)
          4'd1: e.cmd = 4'hF;
          4'd2: begin
            e.cmd = {1'b0, r[16:14]};
            e.addr = r[13:0];
            e.a17 = r[17];
          end
          4'd3, 4'd4: begin
            e.cmd = (cmd == 4'd3) ? 4'hD : 4'hC;
            e.addr = 14'h1000 + (ap ? 14'h0400 : 14'h0)
                     + 14'(col);
          end
          4'd5: e.cmd = 4'hA;
          4'd6: begin e.cmd = 4'hA; e.addr = 14'h0400; end
          4'd7: e.cmd = 4'h9;
          4'd8: begin e.cmd = 4'h8; e.addr = row[13:0]; end
          default: begin
            e.cmd = 4'hE;
            e.addr = 14'h0400;
          end
        endcase
      end
      if (d == 1) begin
        pend[d] = 1'b1;
        hcs[d] = csv;
      end else begin
        e.cs = csv;
      end
    end
    e.rdy = e.init && !pend[d];
    e.par = ^{e.cmd, e.bg, e.ba, e.addr, e.a17};
    ep[d] = e;
  endtask

  // Advance the model on each active edge.
  always @(posedge CLK) begin
    step(0);
    step(1);
  end

  // Compare every DUT pin against the model each cycle.
  always @(negedge CLK) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        nvec++;
        if (dp[d] !== ep[d]) begin
          nerr++;
          $display("FAIL pins dut%0d t=%0t: got %h expected %h",
                   d, $time, dp[d], ep[d]);
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic send(int d, logic [3:0] c, logic [1:0] rk,
                      logic [1:0] g, logic [1:0] a,
                      logic [16:0] r, logic [9:0] cl,
                      logic p, output int waits);
    cmd = c; rank = rk; bg = g; ba = a;
    row = r; col = cl; ap = p;
    v[d] = 1'b1;
    waits = 0;
    while (!dp[d].rdy && waits < 40) begin
      @(negedge CLK);
      waits++;
    end
    if (!dp[d].rdy) begin
      nvec++;
      nerr++;
      $display("FAIL handshake dut%0d: ready never rose", d);
      v[d] = 1'b0;
    end
    @(negedge CLK);
  endtask

  task automatic idle(int d);
    v[d] = 1'b0;
    @(negedge CLK);
  endtask

  task automatic init_check(int d);
    int n;
    n = 0;
    while (!dp[d].rn && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("reset_n low cycles", n, TR);
    n = 0;
    while (!dp[d].cke && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("cke low cycles", n, TC);
    chk("init_done at cke", dp[d].init, 1);
    chk("req_ready at cke", dp[d].rdy, 1);
  endtask

  logic [3:0]  tc [8] = '{4'd4, 4'd5, 4'd6, 4'd7,
                          4'd8, 4'd9, 4'd1, 4'd0};
  logic [16:0] tr [8] = '{17'h0, 17'h0, 17'h0, 17'h0,
                          17'h1ABCD, 17'h0, 17'h0, 17'h0};
  int w;

  initial begin
    rst = 2'b11; v = 2'b00; cmd = '0; rank = '0;
    bg = '0; ba = '0; row = '0; col = '0; ap = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk_en = 1'b1;
    chk("reset cs_n", dp[0].cs, 3'b011);
    chk("reset cmd pins", dp[0].cmd, 4'hF);
    chk("reset reset_n/cke", {dp[0].rn, dp[0].cke}, 0);
    chk("reset ready/init", {dp[0].rdy, dp[0].init}, 0);
    chk("reset addr/par", {dp[0].addr, dp[0].par}, 0);

    rst = 2'b00;
    init_check(0);
    chk("2t ready after init", dp[1].rdy, 1);

    send(0, 4'd2, 2'd1, 2'd2, 2'd1, 17'h12345, 10'h0, 0, w);
    chk("act cs_n", dp[0].cs, 3'b001);
    chk("act cmd pins", dp[0].cmd, 4'b0100);
    chk("act addr", dp[0].addr, 14'h2345);
    chk("act bg/ba", {dp[0].bg, dp[0].ba}, 4'b1001);
    chk("act parity", dp[0].par, 1);

    send(0, 4'd3, 2'd0, 2'd0, 2'd0, 17'h0, 10'h3FF, 1, w);
    chk("rd back-to-back waits", w, 0);
    chk("rd cmd pins", dp[0].cmd, 4'b1101);
    chk("rd addr", dp[0].addr, 14'h17FF);
    chk("rd cs_n", dp[0].cs, 3'b010);
    idle(0);
    chk("idle cs_n", dp[0].cs, 3'b011);
    chk("idle addr held", dp[0].addr, 14'h17FF);

    for (int i = 0; i < 8; i++) begin
      send(0, tc[i], 2'(i % 2), 2'(i), 2'(3 - i % 4),
           tr[i], 10'(10'h155 + i), 1'(i / 4), w);
    end
    send(0, 4'd12, 2'd1, 2'd1, 2'd1, 17'h0, 10'h0, 0, w);
    chk("reserved cmd accepted", w, 0);
    chk("reserved cmd cs_n", dp[0].cs, 3'b011);
    idle(0);

    send(1, 4'd7, 2'd2, 2'd0, 2'd0, 17'h0, 10'h0, 0, w);
    chk("2t ref 1st cs_n", dp[1].cs, 3'b111);
    chk("2t ref 1st cmd", dp[1].cmd, 4'b1001);
    chk("2t ref 1st ready", dp[1].rdy, 0);
    cmd = 4'd5; rank = 2'd0; bg = 2'd1; ba = 2'd2;
    @(negedge CLK);
    chk("2t ref 2nd cs_n", dp[1].cs, 3'b011);
    chk("2t ref 2nd cmd", dp[1].cmd, 4'b1001);
    chk("2t ready after hold", dp[1].rdy, 1);
    @(negedge CLK);
    v[1] = 1'b0;
    chk("2t pre 1st cmd", dp[1].cmd, 4'b1010);
    @(negedge CLK);
    chk("2t pre 2nd cs_n", dp[1].cs, 3'b110);

    send(1, 4'd2, 2'd3, 2'd1, 2'd1, 17'h00FF, 10'h0, 0, w);
    v[1] = 1'b0;
    chk("bad rank 1st cs_n", dp[1].cs, 3'b111);
    @(negedge CLK);
    chk("bad rank 2nd cs_n", dp[1].cs, 3'b111);

    send(1, 4'd2, 2'd1, 2'd3, 2'd2, 17'h1C0DE, 10'h0, 0, w);
    v[1] = 1'b0;
    chk("hold before rst ready", dp[1].rdy, 0);
    rst[1] = 1'b1;
    @(negedge CLK);
    chk("rst in hold cs_n", dp[1].cs, 3'b111);
    chk("rst in hold reset_n/cke", {dp[1].rn, dp[1].cke}, 0);
    chk("rst in hold addr", dp[1].addr, 0);
    @(negedge CLK);
    rst[1] = 1'b0;
    init_check(1);

    send(1, 4'd4, 2'd1, 2'd2, 2'd3, 17'h0, 10'h2AA, 0, w);
    v[1] = 1'b0;
    @(negedge CLK);
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
